bid_request_queue: RTL and testbench
====================================

Name: bid_request_queue

Overview:
- Per-bidder front-end that sits directly upstream of the auction FSM, one instance per bidder (X, Y, Z).
- Buffers bid and retract requests from a bidder agent in a small FIFO.
- Presents them one at a time on the auction's bidder input (bid, retract, bidAmt) while a round is open.
- Captures the auction's same-cycle per-bidder error code and reports it back to the agent as a one-cycle response, applying a programmable backoff after rejected bids.

Parameters:
- DATAWIDTH, 32, width of bid amounts (matches auction datapath).
- DEPTH, 4, FIFO entries; power of two, >= 2.
- BACKOFF, 3, idle cycles inserted after an errored issue; 0 disables backoff.

Ports:
- clk  in  1  single clock; all state on posedge.
- reset  in  1  asynchronous, active-high; clears all state.
- req_valid  in  1  agent request strobe.
- req_ready  out  1  FIFO can accept; equals (count < DEPTH).
- req_retract  in  1  1 = retract request (amount ignored), 0 = bid.
- req_amt  in  DATAWIDTH  bid amount.
- round_open  in  1  high while auction is in its round-started state.
- flush  in  1  synchronous clear of queued requests.
- bid  out  1  to auction bidder input.
- retract  out  1  to auction bidder input.
- bidAmt  out  DATAWIDTH  to auction bidder input.
- bid_err  in  2  auction per-bidder error, valid in the issue cycle: 00 none, 01 invalid request (masked), 10 insufficient funds, 11 reserved (treated as invalid).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_err  out  2  error code of the completed issue.
- rsp_amt  out  DATAWIDTH  amount of the completed issue (0 for retract).
- count  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset values: all outputs 0, except req_ready = 1. FIFO is emptied, FSM goes to CLOSED, and the backoff counter is 0. Reset mid-round drops queued entries and any pending response.
- Push: the entry is written when req_valid && req_ready && !flush. Pushing while full is ignored, with no overflow of state. req_ready does not see a same-cycle pop (no bypass).
- FSM states and transitions:
  - CLOSED: no issue. Go to OPEN when round_open.
  - OPEN: issue the head when count > 0 and !flush.
    - Issuing drives bid = !head.retract, retract = head.retract, bidAmt = head.amt (0 for retract), combinationally from the head.
    - Sample bid_err the same cycle and pop the head.
    - If bid_err != 00 and BACKOFF > 0, load the backoff counter with BACKOFF and go to BACKOFF.
    - Go to CLOSED when !round_open; no issue in that cycle.
  - BACKOFF: no issue. Decrement the counter each cycle and return to OPEN when it reaches 0 (exactly BACKOFF idle cycles). Go to CLOSED immediately if !round_open, clearing the counter.
- Response: registered. rsp_valid pulses the cycle after an issue, carrying the sampled bid_err and the issued amount. At most one issue per cycle, so at most one response per cycle.
- Latency: a push into an empty queue in cycle N with round_open issues in N+1, and its response appears in N+2. Sustained throughput is one issue per cycle when there are no errors.
- Simultaneous push and pop: both occur, and count is unchanged. Pointers wrap modulo DEPTH.
- Flush: empties the FIFO and blocks both issue and push that cycle. FSM state is unchanged. A response already registered from the prior cycle is still delivered.
- Empty in OPEN: bid, retract and bidAmt are 0.
- Outputs bid, retract and bidAmt are 0 in every state other than an OPEN issue cycle.

Optional Feature:
- Macro BIDQ_STATS_EN.
- When defined: adds outputs stat_issued and stat_rejected (both 16 bits). They count issues and issues with bid_err != 00, saturate at 16'hFFFF, and are cleared by reset only.
- When undefined: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Push amounts 5, 7, 9 with round_open = 0, then raise round_open -> bid pulses on 3 consecutive cycles with bidAmt 5, 7, 9; rsp_valid carries err 00 and amounts 5, 7, 9 one cycle later each; count goes 3 -> 0.
- Fill 4 entries with round_open = 0 -> req_ready = 0 and count = 4; a 5th push is ignored; raising round_open lets 4 issues occur, not 5.
- BACKOFF = 3, queue 10, 20 with bid_err = 10 on the first issue -> rsp_err = 10 for amount 10; no issue for exactly 3 cycles; amount 20 issues on the 4th cycle after the first issue.
- Retract request queued -> retract = 1, bid = 0, bidAmt = 0; rsp_amt = 0.
- Assert flush with 3 queued and round_open = 1 -> no issue that cycle; count = 0 next cycle; a concurrent push is dropped.
- Assert reset asynchronously mid-BACKOFF with 2 queued -> outputs are immediately 0, req_ready = 1, count = 0, and the FSM is CLOSED after release.

Source files
------------

// File: rtl/bid_request_queue.sv
// =============================================================================
// Module   : bid_request_queue
// Purpose  : Per-bidder request FIFO that feeds the auction FSM bidder input,
//            returns per-issue error responses and backs off after rejects.
//            Optional statistics counters are built when BIDQ_STATS_EN is defined.
// Revision : 1.0
// =============================================================================
`default_nettype none

module bid_request_queue #(
    parameter int DATAWIDTH = 32,
    parameter int DEPTH     = 4,
    parameter int BACKOFF   = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_retract,
    input  logic [DATAWIDTH-1:0]         req_amt,
    input  logic                         round_open,
    input  logic                         flush,
    output logic                         bid,
    output logic                         retract,
    output logic [DATAWIDTH-1:0]         bidAmt,
    input  logic [1:0]                   bid_err,
    output logic                         rsp_valid,
    output logic [1:0]                   rsp_err,
    output logic [DATAWIDTH-1:0]         rsp_amt,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef BIDQ_STATS_EN
    ,
    output logic [15:0]                  stat_issued,
    output logic [15:0]                  stat_rejected
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int BW = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1;

    typedef enum logic [1:0] {
        ST_CLOSED  = 2'd0,
        ST_OPEN    = 2'd1,
        ST_BACKOFF = 2'd2
    } state_t;

    // Entry layout: {retract, amount}; retract entries store a zero amount.
    logic [DATAWIDTH:0]   r_mem [DEPTH];
    logic [AW-1:0]        r_wptr;
    logic [AW-1:0]        r_rptr;
    logic [CW-1:0]        r_count;
    state_t               r_state;
    logic [BW-1:0]        r_boff;
    logic                 r_rsp_valid;
    logic [1:0]           r_rsp_err;
    logic [DATAWIDTH-1:0] r_rsp_amt;

    logic                 w_push;
    logic                 w_issue;
    logic                 w_err;
    logic                 w_head_ret;
    logic [DATAWIDTH-1:0] w_head_amt;

    assign req_ready  = (r_count < CW'(DEPTH));
    assign w_push     = req_valid && req_ready && !flush;
    assign w_issue    = (r_state == ST_OPEN) && round_open && (r_count != '0) && !flush;
    assign w_err      = (bid_err != 2'b00);
    assign w_head_ret = r_mem[r_rptr][DATAWIDTH];
    assign w_head_amt = r_mem[r_rptr][DATAWIDTH-1:0];

    assign bid       = w_issue && !w_head_ret;
    assign retract   = w_issue && w_head_ret;
    assign bidAmt    = w_issue ? w_head_amt : '0;
    assign rsp_valid = r_rsp_valid;
    assign rsp_err   = r_rsp_err;
    assign rsp_amt   = r_rsp_amt;
    assign count     = r_count;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {req_retract, (req_retract ? {DATAWIDTH{1'b0}} : req_amt)};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + AW'(1);
            end
            if (w_issue) begin
                r_rptr <= r_rptr + AW'(1);
            end
            if (w_push && !w_issue) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push && w_issue) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Backoff counter reaching 1 means this is the last idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_CLOSED;
            r_boff  <= '0;
        end else begin
            case (r_state)
                ST_CLOSED: begin
                    if (round_open) begin
                        r_state <= ST_OPEN;
                    end
                end
                ST_OPEN: begin
                    if (!round_open) begin
                        r_state <= ST_CLOSED;
                    end else if ((BACKOFF > 0) && w_issue && w_err) begin
                        r_state <= ST_BACKOFF;
                        r_boff  <= BW'(BACKOFF);
                    end
                end
                ST_BACKOFF: begin
                    if (!round_open) begin
                        r_state <= ST_CLOSED;
                        r_boff  <= '0;
                    end else if (r_boff <= BW'(1)) begin
                        r_state <= ST_OPEN;
                        r_boff  <= '0;
                    end else begin
                        r_boff <= r_boff - BW'(1);
                    end
                end
                default: begin
                    r_state <= ST_CLOSED;
                    r_boff  <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 2'b00;
            r_rsp_amt   <= '0;
        end else begin
            r_rsp_valid <= w_issue;
            r_rsp_err   <= w_issue ? bid_err : 2'b00;
            r_rsp_amt   <= w_issue ? w_head_amt : '0;
        end
    end

`ifdef BIDQ_STATS_EN
    logic [15:0] r_stat_issued;
    logic [15:0] r_stat_rejected;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stat_issued   <= '0;
            r_stat_rejected <= '0;
        end else if (w_issue) begin
            if (r_stat_issued != 16'hFFFF) begin
                r_stat_issued <= r_stat_issued + 16'd1;
            end
            if (w_err && (r_stat_rejected != 16'hFFFF)) begin
                r_stat_rejected <= r_stat_rejected + 16'd1;
            end
        end
    end

    assign stat_issued   = r_stat_issued;
    assign stat_rejected = r_stat_rejected;
`endif

endmodule

`default_nettype wire

// File: tb/tb_bid_request_queue.sv
// =============================================================================
// Module   : tb_bid_request_queue
// Purpose  : Directed scoreboard bench for bid_request_queue (DEPTH=4, BACKOFF=3).
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_bid_request_queue;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_retract;
    logic [DW-1:0] req_amt;
    logic          round_open;
    logic          flush;
    logic          bid;
    logic          retract;
    logic [DW-1:0] bidAmt;
    logic [1:0]    bid_err;
    logic          rsp_valid;
    logic [1:0]    rsp_err;
    logic [DW-1:0] rsp_amt;
    logic [2:0]    count;
`ifdef BIDQ_STATS_EN
    logic [15:0]   stat_issued;
    logic [15:0]   stat_rejected;
`endif

    // Auction stand-in: rejects an issue whose amount matches err_amt.
    logic          err_en;
    logic [DW-1:0] err_amt;
    logic [1:0]    err_code;

    assign bid_err = (err_en && (bid || retract) && (bidAmt == err_amt)) ? err_code : 2'b00;

    always #5 clk = ~clk;

    bid_request_queue #(.DATAWIDTH(DW), .DEPTH(4), .BACKOFF(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_retract (req_retract),
        .req_amt     (req_amt),
        .round_open  (round_open),
        .flush       (flush),
        .bid         (bid),
        .retract     (retract),
        .bidAmt      (bidAmt),
        .bid_err     (bid_err),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_amt     (rsp_amt),
        .count       (count)
`ifdef BIDQ_STATS_EN
        ,
        .stat_issued   (stat_issued),
        .stat_rejected (stat_rejected)
`endif
    );

    typedef struct {
        logic          ret;
        logic [DW-1:0] amt;
        int            gap;
    } iss_t;

    typedef struct {
        logic [1:0]    err;
        logic [DW-1:0] amt;
    } rsp_t;

    iss_t exp_iss[$];
    rsp_t exp_rsp[$];
    iss_t mon_i;
    rsp_t mon_r;

    int   checks     = 0;
    int   failures   = 0;
    int   cyc        = 0;
    int   last_iss   = -100;
    logic prev_issue = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: actual=present required=absent", name);
    endtask

    always @(posedge clk) cyc++;

    // Monitor: compare every issue and response against the scoreboard queues.
    always @(negedge clk) begin
        if (reset) begin
            prev_issue = 1'b0;
        end else begin
            check("rsp_timing", rsp_valid, prev_issue);
            if (rsp_valid) begin
                if (exp_rsp.size() == 0) begin
                    fail_now("unexpected_rsp");
                end else begin
                    mon_r = exp_rsp.pop_front();
                    check("rsp_err", rsp_err, mon_r.err);
                    check("rsp_amt", rsp_amt, mon_r.amt);
                end
            end
            if (bid || retract) begin
                if (exp_iss.size() == 0) begin
                    fail_now("unexpected_issue");
                end else begin
                    mon_i = exp_iss.pop_front();
                    check("issue_bid", bid, !mon_i.ret);
                    check("issue_retract", retract, mon_i.ret);
                    check("issue_amt", bidAmt, mon_i.amt);
                    if (mon_i.gap != 0) begin
                        check("issue_gap", cyc - last_iss, mon_i.gap);
                    end
                end
                last_iss = cyc;
            end
            prev_issue = bid || retract;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic r, input logic [DW-1:0] a);
        req_valid   = 1'b1;
        req_retract = r;
        req_amt     = a;
        tick();
        req_valid   = 1'b0;
        req_retract = 1'b0;
        req_amt     = '0;
    endtask

    task automatic exp_issue(input logic r, input logic [DW-1:0] a, input int gap,
                             input logic [1:0] e);
        exp_iss.push_back('{ret: r, amt: a, gap: gap});
        exp_rsp.push_back('{err: e, amt: a});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset       = 1'b1;
        req_valid   = 1'b0;
        req_retract = 1'b0;
        req_amt     = '0;
        round_open  = 1'b0;
        flush       = 1'b0;
        err_en      = 1'b0;
        err_amt     = '0;
        err_code    = 2'b00;
        tick();
        tick();
        check("rst_count", count, 0);
        check("rst_req_ready", req_ready, 1);
        check("rst_bid", bid, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_amt", rsp_amt, 0);
        reset = 1'b0;
        tick();

        // Three bids queued while closed, then drained back-to-back.
        push(1'b0, 32'd5);
        push(1'b0, 32'd7);
        push(1'b0, 32'd9);
        check("t1_count_full", count, 3);
        exp_issue(1'b0, 32'd5, 0, 2'b00);
        exp_issue(1'b0, 32'd7, 1, 2'b00);
        exp_issue(1'b0, 32'd9, 1, 2'b00);
        round_open = 1'b1;
        repeat (6) tick();
        check("t1_count_empty", count, 0);
        round_open = 1'b0;
        tick();

        // Fill to DEPTH; fifth push must be dropped.
        push(1'b0, 32'd11);
        push(1'b0, 32'd12);
        push(1'b0, 32'd13);
        push(1'b0, 32'd14);
        check("t2_count_full", count, 4);
        check("t2_ready_full", req_ready, 0);
        push(1'b0, 32'd15);
        check("t2_count_after_overflow", count, 4);
        exp_issue(1'b0, 32'd11, 0, 2'b00);
        exp_issue(1'b0, 32'd12, 1, 2'b00);
        exp_issue(1'b0, 32'd13, 1, 2'b00);
        exp_issue(1'b0, 32'd14, 1, 2'b00);
        round_open = 1'b1;
        repeat (7) tick();
        check("t2_count_empty", count, 0);
        check("t2_ready_empty", req_ready, 1);
        round_open = 1'b0;
        tick();

        // Rejected bid forces three idle cycles before the next issue.
        err_en   = 1'b1;
        err_amt  = 32'd10;
        err_code = 2'b10;
        push(1'b0, 32'd10);
        push(1'b0, 32'd20);
        exp_issue(1'b0, 32'd10, 0, 2'b10);
        exp_issue(1'b0, 32'd20, 4, 2'b00);
        round_open = 1'b1;
        repeat (9) tick();
        check("t3_count_empty", count, 0);
        round_open = 1'b0;
        err_en     = 1'b0;
        tick();

        // Retract carries a zero amount regardless of req_amt.
        push(1'b1, 32'h55);
        push(1'b0, 32'd30);
        exp_issue(1'b1, 32'd0, 0, 2'b00);
        exp_issue(1'b0, 32'd30, 1, 2'b00);
        round_open = 1'b1;
        repeat (4) tick();
        round_open = 1'b0;
        tick();

        // Flush in an OPEN cycle with three queued and a concurrent push.
        push(1'b0, 32'd50);
        push(1'b0, 32'd51);
        push(1'b0, 32'd52);
        check("t5_count_queued", count, 3);
        round_open = 1'b1;
        tick();
        flush     = 1'b1;
        req_valid = 1'b1;
        req_amt   = 32'd99;
        #1;
        check("t5_flush_no_bid", bid, 0);
        tick();
        flush     = 1'b0;
        req_valid = 1'b0;
        req_amt   = '0;
        check("t5_count_flushed", count, 0);
        repeat (3) tick();
        round_open = 1'b0;
        tick();

        // Asynchronous reset while backing off with two entries queued.
        err_en   = 1'b1;
        err_amt  = 32'd60;
        err_code = 2'b01;
        push(1'b0, 32'd60);
        push(1'b0, 32'd61);
        push(1'b0, 32'd62);
        exp_issue(1'b0, 32'd60, 0, 2'b01);
        round_open = 1'b1;
        tick();
        tick();
        tick();
        check("t6_count_pre_reset", count, 2);
        #2;
        reset = 1'b1;
        #1;
        check("t6_rst_bid", bid, 0);
        check("t6_rst_bidAmt", bidAmt, 0);
        check("t6_rst_count", count, 0);
        check("t6_rst_ready", req_ready, 1);
        check("t6_rst_rsp_valid", rsp_valid, 0);
        err_en = 1'b0;
        tick();
        reset = 1'b0;
        push(1'b0, 32'd70);
        exp_issue(1'b0, 32'd70, 0, 2'b00);
        repeat (4) tick();
        check("t6_count_after", count, 0);
        round_open = 1'b0;
        repeat (3) tick();

        check("iss_queue_drained", exp_iss.size(), 0);
        check("rsp_queue_drained", exp_rsp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
